fpu_mul_round16: RTL and testbench

Downstream stage of the FP16 sequential mantissa multiplier. It takes the 22-bit unsigned mantissa product and the two original FP16 operands. It then normalizes, rounds (round-to-nearest-even), handles exponent range and special values, and packs an IEEE-754 half-precision result. Valid/ready handshake on both sides; one transaction in flight.

---
 rtl/fpu_mul_round16_pkg.sv | 23 ++
 rtl/fpu_fp16_classify.sv | 18 +
 rtl/fpu_mul_round16.sv | 185 ++++++++++++++++++
 tb/tb_fpu_mul_round16.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fpu_mul_round16_pkg.sv
// Shared FP16 constants and types for the multiplier round/pack stage.
// The optional flags output is enabled with FPU_MUL_FLAGS_EN.
package fpu_mul_round16_pkg;
   localparam int BIAS  = 15;
   localparam int EXPW  = 5;
   localparam int FRACW = 10;
   localparam int PRODW = 2*FRACW+2;

   localparam logic [15:0] QNAN = 16'h7E00;

   localparam logic [1:0] SP_NONE = 2'd0;
   localparam logic [1:0] SP_NAN  = 2'd1;
   localparam logic [1:0] SP_INF  = 2'd2;
   localparam logic [1:0] SP_ZERO = 2'd3;

   typedef enum logic [1:0] {
      IDLE, NORM, ROUND, OUT
   } fpuMulRoundState_t;

   typedef enum logic [1:0] {
      ZERO, NORMAL, INF, NAN
   } fpuFp16Class_t;
endpackage

// File: rtl/fpu_fp16_classify.sv
// Combinational FP16 operand classifier; subnormals report as ZERO.
// Only the magnitude bits are needed, so the sign is not an input.
module fpu_fp16_classify
   import fpu_mul_round16_pkg::*;
(
   input  logic [14:0]   mag,
   output fpuFp16Class_t cls
);

   always_comb begin
      cls = NORMAL;
      if (mag[14:10] == 5'h00)
         cls = ZERO;
      else if (mag[14:10] == 5'h1F)
         cls = (mag[9:0] == 10'h000) ? INF : NAN;
   end

endmodule

// File: rtl/fpu_mul_round16.sv
// FP16 multiply back end: normalize, round-to-nearest-even, range, pack.
// Define FPU_MUL_FLAGS_EN to add flags = {invalid,overflow,underflow,inexact}.
module fpu_mul_round16
   import fpu_mul_round16_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             inValid,
   output logic             inReady,
   input  logic [15:0]      opA,
   input  logic [15:0]      opB,
   input  logic [PRODW-1:0] prod,
   output logic             outValid,
   input  logic             outReady,
`ifdef FPU_MUL_FLAGS_EN
   output logic [3:0]       flags,
`endif
   output logic [15:0]      result
);

   fpuMulRoundState_t state;

   logic [15:0]      aq;
   logic [15:0]      bq;
   logic [PRODW-1:0] pq;

   fpuFp16Class_t clsA;
   fpuFp16Class_t clsB;

   logic              sign;
   logic signed [6:0] expn;
   logic [9:0]        mant;
   logic              guard;
   logic              sticky;
   logic [1:0]        spec;

   fpu_fp16_classify u_clsA (.mag(aq[14:0]), .cls(clsA));
   fpu_fp16_classify u_clsB (.mag(bq[14:0]), .cls(clsB));

   logic signed [6:0] eSum;
   logic signed [6:0] eNorm;
   logic [9:0]        mNorm;
   logic              gNorm;
   logic              sNorm;
   logic [1:0]        specNorm;
   logic              nanIn;
   logic              infIn;
   logic              zeroIn;

   assign eSum = 7'({2'b00, aq[14:10]} + {2'b00, bq[14:10]}) - 7'(BIAS);

   always_comb begin
      eNorm  = eSum;
      mNorm  = pq[19:10];
      gNorm  = pq[9];
      sNorm  = |pq[8:0];
      if (pq[PRODW-1]) begin
         eNorm = eSum + 7'sd1;
         mNorm = pq[20:11];
         gNorm = pq[10];
         sNorm = |pq[9:0];
      end
   end

   assign nanIn  = (clsA == NAN) || (clsB == NAN)
                || (clsA == INF && clsB == ZERO)
                || (clsA == ZERO && clsB == INF);
   assign infIn  = (clsA == INF) || (clsB == INF);
   assign zeroIn = (clsA == ZERO) || (clsB == ZERO);

   always_comb begin
      specNorm = SP_NONE;
      if (nanIn)
         specNorm = SP_NAN;
      else if (infIn)
         specNorm = SP_INF;
      else if (zeroIn)
         specNorm = SP_ZERO;
   end

   logic              up;
   logic [10:0]       mSum;
   logic signed [6:0] eRnd;
   logic              ovf;
   logic              unf;
   logic [15:0]       resNext;

   // A mantissa carry leaves mSum[9:0] at zero, which is the renormalized value.
   assign up   = guard & (sticky | mant[0]);
   assign mSum = {1'b0, mant} + {10'd0, up};
   assign eRnd = expn + $signed({6'd0, mSum[10]});
   assign ovf  = eRnd >= 7'sd31;
   assign unf  = eRnd <= 7'sd0;

   always_comb begin
      resNext = {sign, eRnd[4:0], mSum[9:0]};
      if (spec == SP_NAN)
         resNext = QNAN;
      else if (spec == SP_INF)
         resNext = {sign, 5'h1F, 10'h000};
      else if (spec == SP_ZERO)
         resNext = {sign, 15'h0000};
      else if (ovf)
         resNext = {sign, 5'h1F, 10'h000};
      else if (unf)
         resNext = {sign, 15'h0000};
   end

`ifdef FPU_MUL_FLAGS_EN
   logic [3:0] flagsNext;

   always_comb begin
      flagsNext = {3'b000, guard | sticky};
      if (spec == SP_NAN)
         flagsNext = 4'b1000;
      else if (spec != SP_NONE)
         flagsNext = 4'b0000;
      else if (ovf)
         flagsNext = 4'b0101;
      else if (unf)
         flagsNext = 4'b0011;
   end
`endif

   assign inReady = (state == IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         aq       <= '0;
         bq       <= '0;
         pq       <= '0;
         sign     <= 1'b0;
         expn     <= '0;
         mant     <= '0;
         guard    <= 1'b0;
         sticky   <= 1'b0;
         spec     <= SP_NONE;
         result   <= '0;
         outValid <= 1'b0;
`ifdef FPU_MUL_FLAGS_EN
         flags    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (inValid) begin
                  aq    <= opA;
                  bq    <= opB;
                  pq    <= prod;
                  state <= NORM;
`ifdef FPU_MUL_FLAGS_EN
                  flags <= '0;
`endif
               end
            end
            NORM: begin
               sign   <= aq[15] ^ bq[15];
               expn   <= eNorm;
               mant   <= mNorm;
               guard  <= gNorm;
               sticky <= sNorm;
               spec   <= specNorm;
               state  <= ROUND;
            end
            ROUND: begin
               result   <= resNext;
               outValid <= 1'b1;
`ifdef FPU_MUL_FLAGS_EN
               flags    <= flagsNext;
`endif
               state    <= OUT;
            end
            OUT: begin
               if (outReady) begin
                  outValid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_round16.sv
// Directed bench for fpu_mul_round16 with hand-computed FP16 results.
// Flag checks are compiled in when FPU_MUL_FLAGS_EN is defined.
module tb_fpu_mul_round16;

   logic        clock;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [15:0] opA;
   logic [15:0] opB;
   logic [21:0] prod;
   logic        outValid;
   logic        outReady;
   logic [15:0] result;
`ifdef FPU_MUL_FLAGS_EN
   logic [3:0]  flags;
`endif

   int passed = 0;
   int total  = 0;

   fpu_mul_round16 dut (
      .clock    (clock),
      .reset    (reset),
      .inValid  (inValid),
      .inReady  (inReady),
      .opA      (opA),
      .opB      (opB),
      .prod     (prod),
      .outValid (outValid),
      .outReady (outReady),
`ifdef FPU_MUL_FLAGS_EN
      .flags    (flags),
`endif
      .result   (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic [21:0] p);
      @(negedge clock);
      opA     = a;
      opB     = b;
      prod    = p;
      inValid = 1'b1;
      @(posedge clock);
      #1 inValid = 1'b0;
   endtask

   task automatic waitOut(output int n);
      n = 0;
      while (outValid !== 1'b1 && n < 20) begin
         @(posedge clock);
         #1 n++;
      end
   endtask

   task automatic xact(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic [21:0] p,
                       input logic [15:0] exp, input logic [3:0] fexp);
      int n;
      check({tag, "_inReady"}, 32'(inReady), 32'd1);
      send(a, b, p);
      waitOut(n);
      check({tag, "_latency"}, 32'(n), 32'd2);
      check({tag, "_result"}, 32'(result), 32'(exp));
`ifdef FPU_MUL_FLAGS_EN
      check({tag, "_flags"}, 32'(flags), 32'(fexp));
`else
      if (fexp === 4'hx) $display("unused");
`endif
      @(posedge clock);
      #1 check({tag, "_drop"}, 32'(outValid), 32'd0);
   endtask

   initial begin
      int n;
      reset    = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b1;
      opA      = '0;
      opB      = '0;
      prod     = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check("rst_inReady", 32'(inReady), 32'd1);
      check("rst_outValid", 32'(outValid), 32'd0);
      check("rst_result", 32'(result), 32'd0);

      xact("basic", 16'h3E00, 16'h3E00, 22'h240000, 16'h4080, 4'b0000);
      xact("tie_up", 16'h3C01, 16'h3E00, 22'h180600, 16'h3E02, 4'b0001);
      xact("tie_even", 16'h3C03, 16'h3E00, 22'h181200, 16'h3E04, 4'b0001);
      xact("ovf", 16'h7BFF, 16'h7BFF, 22'h3FF001, 16'h7C00, 4'b0101);
      xact("neg", 16'hBC00, 16'h3C00, 22'h100000, 16'hBC00, 4'b0000);
      xact("inf_x0", 16'h7C00, 16'h0000, 22'h000000, 16'h7E00, 4'b1000);
      xact("nan", 16'h7E01, 16'h3C00, 22'h100000, 16'h7E00, 4'b1000);
      xact("inf", 16'hFC00, 16'h3C00, 22'h100000, 16'hFC00, 4'b0000);
      xact("zero", 16'h8000, 16'h3C00, 22'h100000, 16'h8000, 4'b0000);
      xact("unf", 16'h0400, 16'h0400, 22'h100000, 16'h0000, 4'b0011);
      xact("carry", 16'h3C00, 16'h3C00, 22'h1FFE01, 16'h4000, 4'b0001);

      outReady = 1'b0;
      send(16'h3E00, 16'h3E00, 22'h240000);
      waitOut(n);
      check("bp_latency", 32'(n), 32'd2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         opA     = 16'h3C00;
         opB     = 16'h4000;
         prod    = 22'h100000;
         inValid = 1'b1;
         check("bp_outValid", 32'(outValid), 32'd1);
         check("bp_result", 32'(result), 32'h4080);
         check("bp_inReady", 32'(inReady), 32'd0);
      end
      @(negedge clock);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clock);
      #1 check("bp_hs_outValid", 32'(outValid), 32'd0);
      check("bp_hs_inReady", 32'(inReady), 32'd1);
      repeat (4) @(posedge clock);
      #1 check("bp_ignored", 32'(outValid), 32'd0);

      send(16'h3E00, 16'h3E00, 22'h240000);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      check("rstmid_outValid", 32'(outValid), 32'd0);
      check("rstmid_result", 32'(result), 32'd0);
      check("rstmid_inReady", 32'(inReady), 32'd1);
      repeat (3) @(posedge clock);
      #1 check("rstmid_quiet", 32'(outValid), 32'd0);

      xact("post_rst", 16'h3C01, 16'h3E00, 22'h180600, 16'h3E02, 4'b0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
